// File: rtl/lot_access_ctrl.sv
// Purpose: arbitrate two entry and two exit lanes onto one enter/exit pulse pair, enforce lot capacity, run a timed gate per entry lane.
// Latency: a request pulse in cycle n becomes pending in n+1 and is served with enter/exit/reject and the lot update visible in n+2.
// Backpressure: none upstream; pending flags hold requests until served, a pulse on an already-pending lane is dropped and sets err.
module lot_access_ctrl #(
   parameter logic [7:0]  CAPACITY    = 8'd200,
   parameter int unsigned GATE_CYCLES = 50_000_000,
   parameter int unsigned GATE_W      = 26
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic [1:0] ent_req_i,
   input  logic [1:0] ext_req_i,
   output logic       enter_o,
   output logic       exit_o,
   output logic [7:0] lot_o,
   output logic       full_o,
   output logic       empty_o,
   output logic [1:0] gate_open_o,
   output logic [1:0] reject_o,
   output logic       err_o
);

   // Timer counts GATE_CYCLES-1 down to 0, so the gate is open for GATE_CYCLES cycles.
   localparam logic [GATE_W-1:0] TIMER_LOAD = GATE_W'(GATE_CYCLES - 1);

   typedef enum logic {
      GATE_CLOSED = 1'b0,
      GATE_OPEN   = 1'b1
   } gate_state_e;

   // Registered state and next-state
   logic [1:0]        ent_pend_q, ent_pend_d;
   logic [1:0]        ext_pend_q, ext_pend_d;
   logic [7:0]        lot_q, lot_d;
   logic              rr_q, rr_d;
   logic              err_q, err_d;
   logic              enter_q, enter_d;
   logic              exit_q, exit_d;
   logic [1:0]        reject_q, reject_d;
   gate_state_e       gate_q [2];
   gate_state_e       gate_d [2];
   logic [GATE_W-1:0] timer_q [2];
   logic [GATE_W-1:0] timer_d [2];

   // Arbitration results for the current cycle
   logic [1:0] gate_open_w;
   logic [1:0] ent_elig;
   logic [1:0] ent_srv;
   logic [1:0] ext_srv;
   logic [1:0] grant;

   // Decode gate state into the per-lane open level used by both arbiter and output.
   always_comb begin
      gate_open_w = '0;
      for (int i = 0; i < 2; i++) begin
         gate_open_w[i] = (gate_q[i] == GATE_OPEN);
      end
   end

   // Pick at most one pending request: exits (lane 0 first), then round-robin among entries whose gate is closed.
   always_comb begin
      ext_srv  = '0;
      ent_srv  = '0;
      ent_elig = ent_pend_q & ~gate_open_w;
      if (ext_pend_q[0]) begin
         ext_srv[0] = 1'b1;
      end else if (ext_pend_q[1]) begin
         ext_srv[1] = 1'b1;
      end else if (ent_elig != 2'b00) begin
         if (ent_elig[rr_q]) begin
            ent_srv[rr_q] = 1'b1;
         end else begin
            ent_srv[~rr_q] = 1'b1;
         end
      end
   end

   // Next-state: service the chosen request, update occupancy, gates, pending flags and error.
   always_comb begin
      ent_pend_d = ent_pend_q;
      ext_pend_d = ext_pend_q;
      lot_d      = lot_q;
      rr_d       = rr_q;
      err_d      = err_q;
      enter_d    = 1'b0;
      exit_d     = 1'b0;
      reject_d   = '0;
      grant      = '0;
      gate_d     = gate_q;
      timer_d    = timer_q;

      // Exit service: an exit with nothing in the lot is consumed and flagged.
      if (ext_srv != 2'b00) begin
         if (lot_q != 8'd0) begin
            exit_d = 1'b1;
            lot_d  = lot_q - 8'd1;
         end else begin
            err_d = 1'b1;
         end
      end

      // Entry service: admit and open the gate, or refuse when full. Pointer moves past the served lane.
      if (ent_srv != 2'b00) begin
         rr_d = ent_srv[0];
         if (lot_q < CAPACITY) begin
            enter_d = 1'b1;
            lot_d   = lot_q + 8'd1;
            grant   = ent_srv;
         end else begin
            reject_d = ent_srv;
         end
      end

      // Per-lane gate FSM: open on grant, count down, close the cycle after the timer reads zero.
      for (int i = 0; i < 2; i++) begin
         case (gate_q[i])
            GATE_CLOSED: begin
               if (grant[i]) begin
                  gate_d[i]  = GATE_OPEN;
                  timer_d[i] = TIMER_LOAD;
               end
            end
            GATE_OPEN: begin
               if (timer_q[i] == '0) begin
                  gate_d[i] = GATE_CLOSED;
               end else begin
                  timer_d[i] = timer_q[i] - GATE_W'(1);
               end
            end
            default: begin
               gate_d[i] = GATE_CLOSED;
            end
         endcase
      end

      // Capture new pulses; a pulse onto a flag that stays pending is an overrun.
      ent_pend_d = (ent_pend_q & ~ent_srv) | ent_req_i;
      ext_pend_d = (ext_pend_q & ~ext_srv) | ext_req_i;
      if ((ent_req_i & ent_pend_q & ~ent_srv) != 2'b00) begin
         err_d = 1'b1;
      end
      if ((ext_req_i & ext_pend_q & ~ext_srv) != 2'b00) begin
         err_d = 1'b1;
      end
   end

   // State register with synchronous reset that overrides everything, including open gates.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         ent_pend_q <= '0;
         ext_pend_q <= '0;
         lot_q      <= '0;
         rr_q       <= 1'b0;
         err_q      <= 1'b0;
         enter_q    <= 1'b0;
         exit_q     <= 1'b0;
         reject_q   <= '0;
         for (int i = 0; i < 2; i++) begin
            gate_q[i]  <= GATE_CLOSED;
            timer_q[i] <= '0;
         end
      end else begin
         ent_pend_q <= ent_pend_d;
         ext_pend_q <= ext_pend_d;
         lot_q      <= lot_d;
         rr_q       <= rr_d;
         err_q      <= err_d;
         enter_q    <= enter_d;
         exit_q     <= exit_d;
         reject_q   <= reject_d;
         for (int i = 0; i < 2; i++) begin
            gate_q[i]  <= gate_d[i];
            timer_q[i] <= timer_d[i];
         end
      end
   end

   assign enter_o     = enter_q;
   assign exit_o      = exit_q;
   assign reject_o    = reject_q;
   assign lot_o       = lot_q;
   assign err_o       = err_q;
   assign gate_open_o = gate_open_w;
   assign full_o      = (lot_q == CAPACITY);
   assign empty_o     = (lot_q == 8'd0);

endmodule

// File: tb/tb_lot_access_ctrl.sv
// Bench for lot_access_ctrl: directed scenarios then random traffic against a cycle-level reference model.
// Expected pulses and level outputs are queued at stimulus time and popped by a negedge monitor.
// Small lot (3) and short gate (4 cycles) so capacity and gate blocking are reached often.
module tb_lot_access_ctrl;

   localparam int CAP  = 3;
   localparam int GATE = 4;

   logic       clk_i = 1'b0;
   logic       reset_i;
   logic [1:0] ent_req_i;
   logic [1:0] ext_req_i;
   logic       enter_o;
   logic       exit_o;
   logic [7:0] lot_o;
   logic       full_o;
   logic       empty_o;
   logic [1:0] gate_open_o;
   logic [1:0] reject_o;
   logic       err_o;

   lot_access_ctrl #(
      .CAPACITY    (8'(CAP)),
      .GATE_CYCLES (GATE),
      .GATE_W      (3)
   ) dut (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .ent_req_i   (ent_req_i),
      .ext_req_i   (ext_req_i),
      .enter_o     (enter_o),
      .exit_o      (exit_o),
      .lot_o       (lot_o),
      .full_o      (full_o),
      .empty_o     (empty_o),
      .gate_open_o (gate_open_o),
      .reject_o    (reject_o),
      .err_o       (err_o)
   );

   always #5 clk_i = ~clk_i;

   int cyc = 0;
   always @(posedge clk_i) cyc <= cyc + 1;

   // Scoreboard records: pulse vector is {enter, exit, reject[1], reject[0]};
   // status vector is {lot, gate_open, err, full, empty}.
   typedef struct {
      int         cyc;
      logic [3:0] vec;
   } ev_t;
   typedef struct {
      int          cyc;
      logic [12:0] vec;
   } st_t;

   ev_t ev_q[$];
   st_t st_q[$];

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: what is visible during the current cycle.
   int m_lot;
   bit m_ent [2];
   bit m_ext [2];
   int m_gl  [2];   // cycles of open gate remaining, 0 means closed
   int m_rr;        // lane that gets first look among entries
   bit m_err;

   task automatic model_step(input logic r, input logic [1:0] e, input logic [1:0] x);
      bit   ent_done [2];
      bit   ext_done [2];
      int   lane;
      logic [3:0] vec;
      st_t  st;
      ev_t  ev;
      vec = 4'b0000;
      ent_done[0] = 0; ent_done[1] = 0;
      ext_done[0] = 0; ext_done[1] = 0;
      lane = -1;
      if (r) begin
         m_lot = 0; m_rr = 0; m_err = 0;
         for (int i = 0; i < 2; i++) begin
            m_ent[i] = 0; m_ext[i] = 0; m_gl[i] = 0;
         end
      end else begin
         if (m_ext[0]) ext_done[0] = 1;
         else if (m_ext[1]) ext_done[1] = 1;
         else begin
            for (int k = 0; k < 2; k++) begin
               int cand;
               cand = (m_rr + k) % 2;
               if (lane < 0 && m_ent[cand] && m_gl[cand] == 0) lane = cand;
            end
            if (lane >= 0) begin
               ent_done[lane] = 1;
               m_rr = 1 - lane;
            end
         end
         for (int i = 0; i < 2; i++) if (m_gl[i] > 0) m_gl[i] = m_gl[i] - 1;
         if (ext_done[0] || ext_done[1]) begin
            if (m_lot > 0) begin
               m_lot = m_lot - 1;
               vec = 4'b0100;
            end else begin
               m_err = 1;
            end
         end
         if (lane >= 0) begin
            if (m_lot < CAP) begin
               m_lot = m_lot + 1;
               vec = 4'b1000;
               m_gl[lane] = GATE;
            end else begin
               vec = (lane == 0) ? 4'b0001 : 4'b0010;
            end
         end
         for (int i = 0; i < 2; i++) begin
            if (e[i] && m_ent[i] && !ent_done[i]) m_err = 1;
            if (x[i] && m_ext[i] && !ext_done[i]) m_err = 1;
            m_ent[i] = (m_ent[i] && !ent_done[i]) || e[i];
            m_ext[i] = (m_ext[i] && !ext_done[i]) || x[i];
         end
      end
      st.cyc = cyc + 1;
      st.vec = {8'(m_lot), (m_gl[1] > 0), (m_gl[0] > 0), m_err, (m_lot == CAP), (m_lot == 0)};
      st_q.push_back(st);
      if (vec != 4'b0000) begin
         ev.cyc = cyc + 1;
         ev.vec = vec;
         ev_q.push_back(ev);
      end
   endtask

   task automatic step(input logic r, input logic [1:0] e, input logic [1:0] x);
      reset_i   = r;
      ent_req_i = e;
      ext_req_i = x;
      model_step(r, e, x);
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 2'b00, 2'b00);
   endtask

   // Monitor: status every cycle, pulses whenever the DUT raises one.
   st_t        mon_st;
   ev_t        mon_ev;
   logic [3:0] mon_act;
   logic [12:0] mon_stat;
   always @(negedge clk_i) begin
      if (cyc >= 1) begin
         mon_stat = {lot_o, gate_open_o, err_o, full_o, empty_o};
         if (st_q.size() != 0 && st_q[0].cyc == cyc) begin
            mon_st = st_q.pop_front();
            n_cmp++;
            if (mon_stat !== mon_st.vec) begin
               n_bad++;
               $display("FAIL status cyc=%0d lot/gate/err/full/empty got %0d/%b/%b/%b/%b want %0d/%b/%b/%b/%b",
                        cyc, mon_stat[12:5], mon_stat[4:3], mon_stat[2], mon_stat[1], mon_stat[0],
                        mon_st.vec[12:5], mon_st.vec[4:3], mon_st.vec[2], mon_st.vec[1], mon_st.vec[0]);
            end
         end
         mon_act = {enter_o, exit_o, reject_o};
         while (ev_q.size() != 0 && ev_q[0].cyc < cyc) begin
            mon_ev = ev_q.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL pulse_missed cyc=%0d got none want %b", mon_ev.cyc, mon_ev.vec);
         end
         if (ev_q.size() != 0 && ev_q[0].cyc == cyc) begin
            mon_ev = ev_q.pop_front();
            n_cmp++;
            if (mon_act !== mon_ev.vec) begin
               n_bad++;
               $display("FAIL pulse cyc=%0d enter/exit/reject got %b want %b", cyc, mon_act, mon_ev.vec);
            end
         end else if (mon_act !== 4'b0000) begin
            n_cmp++;
            n_bad++;
            $display("FAIL pulse_unexpected cyc=%0d got %b want 0000", cyc, mon_act);
         end
      end
   end

   initial begin
      reset_i   = 1'b1;
      ent_req_i = 2'b00;
      ext_req_i = 2'b00;

      // Reset state
      step(1'b1, 2'b00, 2'b00);
      step(1'b1, 2'b00, 2'b00);

      // Single entry on lane 0, gate runs its full course
      step(1'b0, 2'b01, 2'b00);
      idle(7);

      // Fill on alternating lanes, then a refused entry
      step(1'b0, 2'b10, 2'b00);
      idle(6);
      step(1'b0, 2'b01, 2'b00);
      idle(6);
      step(1'b0, 2'b01, 2'b00);
      idle(4);

      // Exit and entry together at full: exit first, entry admitted afterwards
      step(1'b0, 2'b10, 2'b01);
      idle(8);

      // Round-robin with both lanes, then lane 0 blocked by its own open gate
      step(1'b1, 2'b00, 2'b00);
      step(1'b0, 2'b11, 2'b00);
      idle(2);
      step(1'b0, 2'b01, 2'b00);
      idle(9);

      // Exit at zero and overrun on a gate-blocked lane
      step(1'b1, 2'b00, 2'b00);
      step(1'b0, 2'b00, 2'b10);
      idle(3);
      step(1'b1, 2'b00, 2'b00);
      step(1'b0, 2'b01, 2'b00);
      idle(3);
      step(1'b0, 2'b01, 2'b00);
      step(1'b0, 2'b01, 2'b00);
      idle(9);

      // Reset while a gate is open and an exit is pending
      step(1'b1, 2'b00, 2'b00);
      step(1'b0, 2'b01, 2'b00);
      idle(3);
      step(1'b0, 2'b00, 2'b01);
      step(1'b1, 2'b00, 2'b00);
      idle(4);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         logic       r;
         logic [1:0] e;
         logic [1:0] x;
         r = ($urandom_range(0, 199) == 0);
         e = {($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0)};
         x = {($urandom_range(0, 6) == 0), ($urandom_range(0, 6) == 0)};
         step(r, e, x);
      end
      idle(12);

      @(negedge clk_i);
      #1;
      n_cmp++;
      if (ev_q.size() != 0 || st_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain got %0d events %0d status left want 0 0", ev_q.size(), st_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/lot_access_ctrl.md
Name: lot_access_ctrl

Overview:
- Arbitrates two entry lanes and two exit lanes that share one occupancy counter and its enter/exit update pulses.
- Enforces lot capacity and sequences a timed entry gate per entry lane.
- Sits between the per-lane direction FSMs, whose single-cycle enter/exit pulses are its requests, and the occupancy counter / hex display path.
- Keeps its own occupancy mirror so capacity decisions never depend on downstream latency.

Parameters:
- CAPACITY, 8'd200: maximum occupancy. Entry grants are refused when `lot == CAPACITY`.
- GATE_CYCLES, 50_000_000: number of cycles an entry gate stays open after a grant (1 s at 50 MHz).
- GATE_W, 26: width of each gate timer. Must satisfy `2**GATE_W > GATE_CYCLES`.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high; clears all state
- ent_req  in  2  per-lane entry request pulses (one cycle each) from the entry-lane FSMs
- ext_req  in  2  per-lane exit request pulses (one cycle each) from the exit-lane FSMs
- enter  out  1  one-cycle increment pulse to the occupancy counter
- exit  out  1  one-cycle decrement pulse to the occupancy counter
- lot  out  8  internal occupancy mirror, unsigned
- full  out  1  high when `lot == CAPACITY`
- empty  out  1  high when `lot == 0`
- gate_open  out  2  per-entry-lane gate drive, high while open
- reject  out  2  one-cycle pulse per entry lane when a request is refused because the lot is full
- err  out  1  sticky; set on request overrun or exit-at-zero, cleared only by reset

Behaviour:
- Reset values: every output is 0 except `empty`, which is 1 because `lot` is 0. Pending flags, timers, the round-robin pointer and `err` are all cleared.
- Request capture: a request high in cycle n sets that lane's pending flag, visible in cycle n+1.
- Overrun: a new pulse on a lane whose flag is already pending is dropped and sets `err`. A pending flag cleared and re-set on the same edge counts as a new capture, not an overrun.
- Service rate: at most one pending request is serviced per cycle, and only one of `enter`/`exit` is ever high in a cycle.
- Priority order, highest first:
  1. Pending exits, lane 0 before lane 1.
  2. Pending entries whose gate is CLOSED, chosen round-robin; the pointer starts at lane 0 and advances past the lane just granted or rejected.
- Latency: a request pending in cycle n+1 and chosen there produces its outputs, and the `lot` update, in cycle n+2. Minimum request-to-pulse latency is 2 cycles.
- Exit service:
  - If `lot > 0`: `exit` pulses, `lot` decrements, the flag clears.
  - If `lot == 0`: no pulse, `lot` holds at 0, the flag clears, `err` sets.
- Entry service:
  - If `lot < CAPACITY`: `enter` pulses, `lot` increments, the flag clears, and that lane's gate goes OPEN in the same cycle as `enter`.
  - Otherwise (full): `reject[lane]` pulses, the flag clears, the gate stays CLOSED.
- Per-lane gate FSM:
  - CLOSED → OPEN on a grant; the timer loads `GATE_CYCLES-1`.
  - OPEN decrements the timer each cycle; OPEN → CLOSED the cycle after the timer reads 0.
  - `gate_open` is therefore high for exactly GATE_CYCLES cycles.
  - While OPEN, that lane's pending entry stays pending and is not arbitrated. Other lanes are unaffected.
- Simultaneous events:
  - Exit and entry pending together: the exit is served first and the entry on a later cycle, so a full lot admits the waiting car without a reject.
  - `lot` never wraps: it is bounded to 0..CAPACITY by construction.
- `full`/`empty` are combinational from `lot`.
- Reset mid-operation: reset overrides everything on the next edge. Open gates close immediately, pending requests are discarded, and no `enter`/`exit` pulse is issued in the cycle after reset.

Test Plan (bench uses CAPACITY=3, GATE_CYCLES=4):
- Single entry: `ent_req[0]` pulse at cycle 1 → `enter` high only at cycle 3; `lot` 0→1 at cycle 3; `gate_open[0]` high cycles 3–6; `empty` falls at cycle 3.
- Fill and reject: 3 entries on alternating lanes, then 1 more on lane 0 → three `enter` pulses, `lot`=3, `full`=1; the 4th produces `reject[0]` and no `enter`, `lot` stays 3.
- Simultaneous exit and entry at full: `lot`=3, `ent_req[1]` and `ext_req[0]` in the same cycle → `exit` two cycles later (`lot` 2), `enter` the next cycle (`lot` 3), no `reject`.
- Round-robin and gate blocking: both `ent_req` bits in the same cycle, `lot`=0 → lane 0 granted at cycle+2, lane 1 at cycle+3; a second lane-0 request while `gate_open[0]` is high waits until the gate closes, then is granted.
- Errors: `ext_req[1]` with `lot`=0 → no `exit`, `lot` stays 0, `err`=1. Two `ent_req[0]` pulses in consecutive cycles while the lane-0 gate is open → `err`=1 and only one grant after the gate closes.
- Reset mid-operation: assert `reset` for 1 cycle while `gate_open[0]`=1 and an exit is pending → next cycle all outputs 0, `empty`=1, no `exit` pulse issued.
